bus_master_port: RTL and testbench
==================================

# bus_master_port

Master-side serial bus interface that feeds one master port (m1 or m2) of the two-master / three-slave serial bus arbiter. Accepts a parallel write transaction from host logic, arbitrates for the bus, serially issues the 2-bit slave select during the arbiter's address-sampling window, then streams address and data bits under the slave's ready handshake. Reports completion or error back to the host.

## Interface
- ADDR_W, 12, slave address width in bits
- DATA_W, 8, write data width in bits
- TIMEOUT, 16, cycles to wait for slave ready before abort (used only with BUS_MASTER_TIMEOUT_EN)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  host transaction request
- req_ready  out  1  high in IDLE; transaction accepted when req_valid && req_ready
- req_slave  in  2  slave select: 0→S1, 1→S2, 2→S3, 3 illegal
- req_addr  in  ADDR_W  slave address
- req_data  in  DATA_W  write data
- done  out  1  one-cycle pulse, transaction completed
- err  out  1  one-cycle pulse, illegal slave or timeout
- m_request  out  1  to arbiter mX_request
- m_address_valid  out  1  to arbiter mX_address_valid
- m_address  out  1  serial address/select bit
- m_data  out  1  serial data bit
- m_valid  out  1  frame bit valid
- m_available  in  1  from arbiter mX_available
- m_ready  in  1  from arbiter mX_ready (connected slave's ready)

## Operation
- Reset: state IDLE; all bus outputs 0, done=0, err=0, req_ready=1; shift registers and counters cleared. Reset mid-transaction abandons it with no done/err.
- Accept latches req_slave/addr/data into local registers; frame length N = max(ADDR_W, DATA_W).
- States:
  - IDLE: accept → ARB; if req_slave==3 → ERR instead.
  - ARB: m_request=1, m_address_valid=1, m_address=sel[1]. If m_available=1 → SEL1, else stay.
  - SEL1: m_request=1, m_address=sel[1], m_address_valid=0. If m_available=0 (lost to other master) → ARB; else → SEL0.
  - SEL0: m_request=1, m_address=sel[0] → CONN.
  - CONN: m_request=1, address/data/valid 0 → WAIT.
  - WAIT: m_request=1. m_ready=1 → SHIFT (bit counter cleared).
  - SHIFT: m_request=1, m_valid=1; m_address=addr bit i, m_data=data bit i, LSB first; bit index ≥ width drives 0. Counter advances only on cycles with m_ready=1 (stall otherwise, bits held). After bit N-1 accepted → RELEASE.
  - RELEASE: all bus outputs 0, done=1 → IDLE.
  - ERR: all bus outputs 0, err=1 → IDLE.
- m_address_valid is high only in ARB; it must be low in every later state so the arbiter does not re-enter address sampling.
- Counter width $clog2(N+1); TIMEOUT counter width $clog2(TIMEOUT+1).

## Timing
- Accept at edge 0; ARB cycle 1; SEL1 cycle 2; SEL0 cycle 3; CONN cycle 4; WAIT cycle 5; first frame bit cycle 6 when uncontended and m_ready=1.
- Unstalled frame occupies N cycles; done in cycle 6+N; req_ready high again cycle 7+N.
- All outputs registered-state decoded; no combinational path from m_ready to bus outputs except stall hold.
- Arbitration loss costs at least 2 cycles (SEL1→ARB) and repeats until won.

## Configuration
- BUS_MASTER_TIMEOUT_EN defined: counter runs in WAIT and in SHIFT while m_ready=0; reaching TIMEOUT consecutive not-ready cycles → ERR (bus released, err pulse). Counter reset on each m_ready=1.
- Undefined: no counter; WAIT/SHIFT stall indefinitely.

## Structure
- Shared package bus_pkg: slave select localparams (SEL_S1=0, SEL_S2=1, SEL_S3=2), state enum, frame-length function.
- Natural sub-module: bus_piso (parallel-in serial-out LSB-first shifter with load/enable), instantiated twice (address, data).

## Test plan
- Uncontended write slave=1, addr=0x0A5, data=0x3C, m_ready tied 1 → m_address sel bits 0,1 in cycles 2–3; 12 valid bits from cycle 6; done in cycle 18.
- req_slave=3 → err pulse cycle 1, m_request never asserted.
- m_available=0 during SEL1 once → return to ARB, m_address_valid reasserted, transaction completes, single done.
- m_ready low 3 cycles at bit 4 → bits 4 held, m_valid stays 1, done delayed by 3 cycles.
- BUS_MASTER_TIMEOUT_EN, TIMEOUT=16, m_ready held 0 → err after 16 WAIT cycles, m_request drops next cycle.
- Reset asserted in SHIFT → next cycle all bus outputs 0, req_ready=1, no done/err.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus master port: slave selects, FSM states, frame length.
// No logic; no latency; no backpressure.
package bus_pkg;

    localparam logic [1:0] SEL_S1  = 2'd0;
    localparam logic [1:0] SEL_S2  = 2'd1;
    localparam logic [1:0] SEL_S3  = 2'd2;
    localparam logic [1:0] SEL_BAD = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_SEL1,
        ST_SEL0,
        ST_CONN,
        ST_WAIT,
        ST_SHIFT,
        ST_RELEASE,
        ST_ERR
    } state_t;

    // Address and data travel side by side, so the frame is as long as the wider field.
    function automatic int frame_len(input int addr_w, input int data_w);
        return (addr_w > data_w) ? addr_w : data_w;
    endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Host request/response and arbiter-facing serial signals of one bus master port.
// Pure wiring; no latency; host side is valid/ready, bus side follows m_ready.
interface bus_master_port_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_slave;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              done;
    logic              err;

    logic              m_request;
    logic              m_address_valid;
    logic              m_address;
    logic              m_data;
    logic              m_valid;
    logic              m_available;
    logic              m_ready;

    modport master (
        input  req_valid, req_slave, req_addr, req_data, m_available, m_ready,
        output req_ready, done, err,
        output m_request, m_address_valid, m_address, m_data, m_valid
    );

    modport slave (
        output req_valid, req_slave, req_addr, req_data, m_available, m_ready,
        input  req_ready, done, err,
        input  m_request, m_address_valid, m_address, m_data, m_valid
    );

endinterface

// File: rtl/bus_piso.sv
// Parallel-in serial-out shifter, LSB first; zeros fill from the top so bits past W read 0.
// Load takes effect next cycle; i_en advances one bit per cycle, holds when low.
module bus_piso #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_dat,
    output logic         o_bit
);

    logic [W-1:0] r_sh;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_dat;
        end else if (i_en) begin
            r_sh <= {1'b0, r_sh[W-1:1]};
        end
    end

    assign o_bit = r_sh[0];

endmodule

// File: rtl/bus_master_port.sv
// Master port: arbitrate, send 2-bit select, stream address/data bits; optional BUS_MASTER_TIMEOUT_EN.
// First frame bit 6 cycles after accept when uncontended; done after N accepted bits.
// Frame bits stall while m_ready is low; host sees req_ready only in IDLE.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    bus_master_port_if.master bus
);

    localparam int                N        = frame_len(ADDR_W, DATA_W);
    localparam int                CNT_W    = $clog2(N + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(N - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             w_accept;
    logic             w_shift_en;
    logic             w_timeout;
    logic             w_addr_bit;
    logic             w_data_bit;

    assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
    assign w_shift_en = (r_state == ST_SHIFT) && bus.m_ready;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_stalled;

    // Counts consecutive not-ready cycles; any ready cycle or leaving WAIT/SHIFT restarts it.
    assign w_stalled = ((r_state == ST_WAIT) || (r_state == ST_SHIFT)) && !bus.m_ready;
    assign w_timeout = w_stalled && (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || !w_stalled) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= '0;
        end else if (w_accept) begin
            r_sel <= bus.req_slave;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_WAIT)) begin
            r_bit_cnt <= '0;
        end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    bus_piso #(.W(ADDR_W)) u_addr_piso (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_en   (w_shift_en),
        .i_dat  (bus.req_addr),
        .o_bit  (w_addr_bit)
    );

    bus_piso #(.W(DATA_W)) u_data_piso (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_en   (w_shift_en),
        .i_dat  (bus.req_data),
        .o_bit  (w_data_bit)
    );

    // m_address_valid is confined to ARB so the arbiter samples the select only once per attempt.
    always_comb begin
        w_state_nxt         = r_state;
        bus.req_ready       = 1'b0;
        bus.done            = 1'b0;
        bus.err             = 1'b0;
        bus.m_request       = 1'b0;
        bus.m_address_valid = 1'b0;
        bus.m_address       = 1'b0;
        bus.m_data          = 1'b0;
        bus.m_valid         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_nxt = (bus.req_slave == SEL_BAD) ? ST_ERR : ST_ARB;
                end
            end
            ST_ARB: begin
                bus.m_request       = 1'b1;
                bus.m_address_valid = 1'b1;
                bus.m_address       = r_sel[1];
                if (bus.m_available) begin
                    w_state_nxt = ST_SEL1;
                end
            end
            ST_SEL1: begin
                bus.m_request = 1'b1;
                bus.m_address = r_sel[1];
                w_state_nxt   = bus.m_available ? ST_SEL0 : ST_ARB;
            end
            ST_SEL0: begin
                bus.m_request = 1'b1;
                bus.m_address = r_sel[0];
                w_state_nxt   = ST_CONN;
            end
            ST_CONN: begin
                bus.m_request = 1'b1;
                w_state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                bus.m_request = 1'b1;
                if (bus.m_ready) begin
                    w_state_nxt = ST_SHIFT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_SHIFT: begin
                bus.m_request = 1'b1;
                bus.m_valid   = 1'b1;
                bus.m_address = w_addr_bit;
                bus.m_data    = w_data_bit;
                if (bus.m_ready && (r_bit_cnt == LAST_BIT)) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_RELEASE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                bus.err     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Self-checking bench for bus_master_port: directed table, reset/timeout sequences, random transactions.
module tb_bus_master_port;

    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int N       = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAXC    = 120;

    typedef struct {
        logic [1:0]        slave;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                arb_wait;
        int                losses;
        int                wait_lo;
        int                stall_bit;
        int                stall_len;
        int                exp_done;   // 0 means an err pulse in cycle 1 is expected
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_master_port_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    bus_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic rdy[MAXC+1];
    logic av[MAXC+1];
    logic tr_adr[MAXC+1];
    logic tr_adv[MAXC+1];
    logic tr_rr[MAXC+1];
    logic tr_req[MAXC+1];
    int   done_cyc, done_cnt, err_cyc, err_cnt, req_cnt, adv_cnt, vld_cnt, cap_n;
    logic [N-1:0] cap_addr, cap_data;
    logic rr0, rr_after;

    vec_t vt[7];
    int   off, s, got, cyc, d_exp, zeros, pulses;
    logic [1:0] sl;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] da;
    int   aw, ls;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] out_vec();
        return {bif.req_ready, bif.done, bif.err, bif.m_request,
                bif.m_address_valid, bif.m_address, bif.m_data, bif.m_valid};
    endfunction

    task automatic build_pattern(input int arb_wait, input int losses, input int wait_lo,
                                 input int stall_bit, input int stall_len);
        int base;
        for (int c = 0; c <= MAXC; c++) begin
            av[c]  = 1'b1;
            rdy[c] = 1'b1;
        end
        av[0] = 1'b0;
        for (int c = 1; c <= arb_wait; c++) av[c] = 1'b0;
        for (int j = 0; j < losses; j++) av[arb_wait + 2 + 2*j] = 1'b0;
        base = 5 + arb_wait + 2*losses;
        for (int i = 0; i < wait_lo; i++) rdy[base + i] = 1'b0;
        for (int i = 0; i < stall_len; i++) rdy[base + 1 + wait_lo + stall_bit + i] = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle; accept happens at the next edge (edge 0).
    task automatic run_txn(input logic [1:0] tsl, input logic [ADDR_W-1:0] tad,
                           input logic [DATA_W-1:0] tda);
        int end_c;
        end_c = 0;
        done_cyc = 0; done_cnt = 0; err_cyc = 0; err_cnt = 0;
        req_cnt = 0; adv_cnt = 0; vld_cnt = 0; cap_n = 0;
        cap_addr = '0; cap_data = '0; rr_after = 1'b0;
        for (int c = 0; c <= MAXC; c++) begin
            tr_adr[c] = 1'b0; tr_adv[c] = 1'b0; tr_rr[c] = 1'b0; tr_req[c] = 1'b0;
        end
        bif.req_valid   = 1'b1;
        bif.req_slave   = tsl;
        bif.req_addr    = tad;
        bif.req_data    = tda;
        bif.m_ready     = rdy[0];
        bif.m_available = av[0];
        @(negedge clk);
        rr0 = bif.req_ready;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        bif.req_slave = 2'($urandom);
        bif.req_addr  = ADDR_W'($urandom);
        bif.req_data  = DATA_W'($urandom);
        for (int c = 1; c <= MAXC; c++) begin
            bif.m_ready     = rdy[c];
            bif.m_available = av[c];
            @(negedge clk);
            tr_adr[c] = bif.m_address;
            tr_adv[c] = bif.m_address_valid;
            tr_rr[c]  = bif.req_ready;
            tr_req[c] = bif.m_request;
            if (bif.m_request)       req_cnt++;
            if (bif.m_address_valid) adv_cnt++;
            if (bif.m_valid)         vld_cnt++;
            if (bif.m_valid && bif.m_ready) begin
                if (cap_n < N) begin
                    cap_addr[cap_n] = bif.m_address;
                    cap_data[cap_n] = bif.m_data;
                end
                cap_n++;
            end
            if (bif.done) begin done_cnt++; if (done_cyc == 0) done_cyc = c; end
            if (bif.err)  begin err_cnt++;  if (err_cyc == 0)  err_cyc = c;  end
            if (end_c == 0 && (bif.done || bif.err)) end_c = c;
            if (end_c != 0 && c == end_c + 1) rr_after = bif.req_ready;
            @(posedge clk); #1;
            if (end_c != 0 && c >= end_c + 2) break;
        end
        bif.m_ready     = 1'b0;
        bif.m_available = 1'b0;
    endtask

    task automatic check_txn(input logic [1:0] tsl, input logic [ADDR_W-1:0] tad,
                             input logic [DATA_W-1:0] tda, input int toff, input int adv_exp,
                             input int exp_done, input int exp_vld);
        logic [N-1:0] ea, ed;
        ea = '0;
        ed = '0;
        for (int i = 0; i < N; i++) begin
            if (i < ADDR_W) ea[i] = tad[i];
            if (i < DATA_W) ed[i] = tda[i];
        end
        chk("req_ready_idle", rr0, 1);
        chk("req_ready_busy", tr_rr[1], 0);
        chk("req_ready_after", rr_after, 1);
        if (exp_done == 0) begin
            chk("err_cycle", err_cyc, 1);
            chk("err_pulses", err_cnt, 1);
            chk("done_pulses", done_cnt, 0);
            chk("m_request_cycles", req_cnt, 0);
            chk("addr_valid_cycles", adv_cnt, 0);
            chk("m_valid_cycles", vld_cnt, 0);
        end else begin
            chk("done_cycle", done_cyc, exp_done);
            chk("done_pulses", done_cnt, 1);
            chk("err_pulses", err_cnt, 0);
            chk("sel_hi_bit", tr_adr[toff + 2], tsl[1]);
            chk("sel_lo_bit", tr_adr[toff + 3], tsl[0]);
            chk("addr_valid_cycles", adv_cnt, adv_exp);
            chk("addr_valid_last_arb", tr_adv[toff + 1], 1);
            chk("m_request_cycles", req_cnt, exp_done - 1);
            chk("m_request_at_done", tr_req[exp_done], 0);
            chk("m_valid_cycles", vld_cnt, exp_vld);
            chk("frame_bits", cap_n, N);
            chk("addr_stream", cap_addr, ea);
            chk("data_stream", cap_data, ed);
        end
    endtask

    initial begin
        vt[0] = '{2'd1, 12'h0A5, 8'h3C, 0, 0, 0, 0,  0, 18};
        vt[1] = '{2'd3, 12'h123, 8'h45, 0, 0, 0, 0,  0, 0};
        vt[2] = '{2'd0, 12'hFFF, 8'hFF, 0, 0, 0, 4,  3, 21};
        vt[3] = '{2'd2, 12'h800, 8'h81, 0, 1, 0, 0,  0, 20};
        vt[4] = '{2'd1, 12'h5A5, 8'hA5, 2, 0, 0, 0,  0, 20};
        vt[5] = '{2'd2, 12'h001, 8'h80, 0, 0, 3, 11, 1, 22};
        vt[6] = '{2'd0, 12'h000, 8'h00, 1, 2, 0, 7,  2, 25};

        reset = 1'b1;
        bif.req_valid = 1'b0; bif.req_slave = '0; bif.req_addr = '0; bif.req_data = '0;
        bif.m_ready = 1'b0; bif.m_available = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs", out_vec(), 8'b1000_0000);
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            build_pattern(vt[v].arb_wait, vt[v].losses, vt[v].wait_lo, vt[v].stall_bit,
                          vt[v].stall_len);
            run_txn(vt[v].slave, vt[v].addr, vt[v].data);
            off = vt[v].arb_wait + 2*vt[v].losses;
            check_txn(vt[v].slave, vt[v].addr, vt[v].data, off,
                      vt[v].arb_wait + 1 + vt[v].losses, vt[v].exp_done,
                      vt[v].exp_done - 6 - off - vt[v].wait_lo);
        end

        // Reset in the middle of the frame abandons the transaction silently.
        bif.req_valid = 1'b1; bif.req_slave = 2'd1; bif.req_addr = 12'h3C3; bif.req_data = 8'h5A;
        bif.m_ready = 1'b1; bif.m_available = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("shift_before_reset", bif.m_valid, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("outputs_after_reset", out_vec(), 8'b1000_0000);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bif.done || bif.err || bif.m_request) pulses++;
        end
        chk("quiet_after_reset", pulses, 0);
        @(posedge clk); #1;

`ifdef BUS_MASTER_TIMEOUT_EN
        build_pattern(0, 0, 0, 0, 0);
        for (int c = 0; c <= MAXC; c++) rdy[c] = 1'b0;
        run_txn(2'd0, 12'h111, 8'h22);
        chk("timeout_err_cycle", err_cyc, 5 + TIMEOUT);
        chk("timeout_request_cycles", req_cnt, 4 + TIMEOUT);
        chk("timeout_request_drop", tr_req[5 + TIMEOUT], 0);
        chk("timeout_no_done", done_cnt, 0);
        chk("timeout_req_ready", rr_after, 1);
`endif

        for (int t = 0; t < 40; t++) begin
            sl = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = ADDR_W'($urandom);
            da = DATA_W'($urandom);
            aw = $urandom_range(0, 2);
            ls = $urandom_range(0, 1);
            build_pattern(aw, ls, 0, 0, 0);
            zeros = 0;
            for (int c = 0; c <= MAXC; c++) begin
                rdy[c] = ($urandom_range(0, 3) != 0) || (zeros >= 4);
                zeros  = rdy[c] ? 0 : zeros + 1;
            end
            off = aw + 2*ls;
            d_exp = 0;
            s = 5 + off;
            if (sl != 2'd3) begin
                // Connection starts at the first ready cycle in WAIT; done follows the N-th ready frame cycle.
                while (!rdy[s] && s < MAXC) s++;
                got = 0;
                cyc = s;
                while (got < N && cyc < MAXC) begin
                    cyc++;
                    if (rdy[cyc]) got++;
                end
                d_exp = cyc + 1;
            end
            run_txn(sl, ad, da);
            check_txn(sl, ad, da, off, aw + 1 + ls, d_exp, d_exp - 1 - s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
